// File: rtl/riscv_dmem_if.sv
// riscv_dmem_if: core data-memory bus plus console TX stream
interface riscv_dmem_if;
    logic [31:0] dmem_addr;
    logic [1:0]  dmem_op;
    logic [31:0] dmem_data_o;
    logic [31:0] dmem_data_i;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    modport master(output dmem_addr, dmem_op, dmem_data_o, tx_ready, input dmem_data_i, tx_data, tx_valid);
    modport slave(input dmem_addr, dmem_op, dmem_data_o, tx_ready, output dmem_data_i, tx_data, tx_valid);
endinterface

// File: rtl/riscv_dmem.sv
// riscv_dmem: word RAM with byte-lane stores, shifted loads, console FIFO and counter MMIO
module riscv_dmem #(
    parameter int          RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input logic         clk,
    input logic         rst,
    riscv_dmem_if.slave io_dmem
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [1:0] OP_SB = 2'd1, OP_SH = 2'd2, OP_SW = 2'd3;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [FW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic [31:0]   r_cycle, r_drop;
    logic          r_mis;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off, w_lo, w_op;
    logic [31:0]   w_d, w_word, w_wd, w_sd;
    logic [3:0]    w_be, w_cnt;
    logic          w_mmio, w_st, w_empty, w_full, w_pop, w_push, w_acc, w_mis_st, w_unused;

    assign w_op     = io_dmem.dmem_op;
    assign w_d      = io_dmem.dmem_data_o;
    assign w_idx    = io_dmem.dmem_addr[AW+1:2];
    assign w_off    = io_dmem.dmem_addr[3:2];
    assign w_lo     = io_dmem.dmem_addr[1:0];
    assign w_mmio   = io_dmem.dmem_addr[31] == MMIO_BASE[31];
    assign w_st     = w_op != 2'd0;
    assign w_unused = &{1'b0, io_dmem.dmem_addr[30:AW+2]};

    assign w_empty = r_count == '0;
    assign w_full  = r_count == CW'(FIFO_DEPTH);
    assign w_pop   = !w_empty & io_dmem.tx_ready;
    assign w_push  = w_st & w_mmio & (w_off == 2'd0);
    // A full FIFO still takes a push when the same edge pops its head.
    assign w_acc   = w_push & (!w_full | w_pop);
    assign w_cnt   = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);

    assign w_word = !w_mmio        ? r_ram[w_idx] :
                    w_off == 2'd0  ? 32'd0 :
                    w_off == 2'd1  ? {24'd0, w_cnt, 1'b0, r_mis, w_full, w_empty} :
                    w_off == 2'd2  ? r_cycle : r_drop;
    assign io_dmem.dmem_data_i = w_word >> {w_lo, 3'b000};
    assign io_dmem.tx_valid    = !w_empty;
    assign io_dmem.tx_data     = w_empty ? 8'd0 : r_fifo[r_rp];

    assign w_be = (!w_st | w_mmio) ? 4'b0000 :
                  w_op == OP_SB    ? 4'b0001 << w_lo :
                  w_op == OP_SH    ? (w_lo[0] ? 4'b0000 : w_lo[1] ? 4'b1100 : 4'b0011) :
                  (w_lo == 2'd0 ? 4'b1111 : 4'b0000);
    assign w_mis_st = w_st & !w_mmio & ((w_op == OP_SH & w_lo[0]) | (w_op == OP_SW & w_lo != 2'd0));
    assign w_wd = w_op == OP_SB ? {4{w_d[7:0]}} : w_op == OP_SH ? {2{w_d[15:0]}} : w_d;
    assign w_sd = w_op == OP_SB ? {24'd0, w_d[7:0]} : w_op == OP_SH ? {16'd0, w_d[15:0]} : w_d;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (w_be[b]) r_ram[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
        if (w_acc) r_fifo[r_wp] <= w_d[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_cycle <= '0;
            r_drop  <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_wp    <= r_wp + FW'(w_acc);
            r_rp    <= r_rp + FW'(w_pop);
            r_count <= r_count + CW'(w_acc) - CW'(w_pop);
            r_cycle <= (w_st & w_mmio & w_off == 2'd2) ? w_sd : r_cycle + 32'd1;
            if (w_st & w_mmio & w_off == 2'd3)
                r_drop <= '0;
            else if (w_push & !w_acc & r_drop != 32'hFFFF_FFFF)
                r_drop <= r_drop + 32'd1;
            if (w_mis_st)
                r_mis <= 1'b1;
            else if (w_st & w_mmio & w_off == 2'd1)
                r_mis <= 1'b0;
        end
    end
endmodule

// File: tb/tb_riscv_dmem.sv
// tb_riscv_dmem: byte-array/queue reference model checked every cycle, plus literal expectations
module tb_riscv_dmem;
    localparam logic [31:0] TX = 32'h8000_0000, ST = 32'h8000_0004, CY = 32'h8000_0008, DR = 32'h8000_000C;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    riscv_dmem_if bus();
    riscv_dmem dut(.clk(clk), .rst(rst), .io_dmem(bus));

    always #5 clk = ~clk;

    logic [7:0]  m_mem [4096];
    logic [7:0]  m_q[$];
    logic [31:0] m_cyc, m_drop;
    logic        m_mis;

    function automatic logic [31:0] m_rd(logic [31:0] a);
        logic [31:0] w;
        int n = m_q.size();
        if (a[31])
            case (a[3:2])
                2'd0: w = 32'd0;
                2'd1: w = {24'd0, 4'(n > 15 ? 15 : n), 1'b0, m_mis, n == 8, n == 0};
                2'd2: w = m_cyc;
                default: w = m_drop;
            endcase
        else
            w = {m_mem[{a[11:2], 2'd3}], m_mem[{a[11:2], 2'd2}], m_mem[{a[11:2], 2'd1}], m_mem[{a[11:2], 2'd0}]};
        return w >> (8 * a[1:0]);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cyc  = 32'd0;
        m_drop = 32'd0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] a = bus.dmem_addr, d = bus.dmem_data_o, sd;
        logic [1:0]  op = bus.dmem_op;
        bit pop  = m_q.size() != 0 && bus.tx_ready;
        bit full = m_q.size() == 8;
        bit push = 0;
        sd = op == 2'd1 ? (d & 32'hFF) : op == 2'd2 ? (d & 32'hFFFF) : d;
        m_cyc = m_cyc + 32'd1;
        if (op != 2'd0 && a[31])
            case (a[3:2])
                2'd0: push = 1;
                2'd1: m_mis = 1'b0;
                2'd2: m_cyc = sd;
                default: m_drop = 32'd0;
            endcase
        else if (op == 2'd1)
            m_mem[a[11:0]] = d[7:0];
        else if (op == 2'd2) begin
            if (a[0]) m_mis = 1'b1;
            else for (int i = 0; i < 2; i++) m_mem[12'(a[11:0] + i)] = d[8*i +: 8];
        end else if (op == 2'd3) begin
            if (a[1:0] != 2'd0) m_mis = 1'b1;
            else for (int i = 0; i < 4; i++) m_mem[12'(a[11:0] + i)] = d[8*i +: 8];
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) m_q.push_back(d[7:0]);
            else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
        end
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic drive(logic [31:0] a, logic [1:0] op = 2'd0, logic [31:0] d = 32'd0, logic r = 1'b0);
        tick();
        bus.dmem_addr   = a;
        bus.dmem_op     = op;
        bus.dmem_data_o = d;
        bus.tx_ready    = r;
    endtask

    task automatic expect_rd(string n, logic [31:0] e);
        #1;
        chk(n, bus.dmem_data_i, e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.dmem_data_i !== m_rd(bus.dmem_addr) || bus.tx_valid !== (m_q.size() != 0) ||
                bus.tx_data !== (m_q.size() != 0 ? m_q[0] : 8'h00)) begin
                failures++;
                $display("FAIL model t=%0t addr=%h: got rd=%h v=%b d=%h expected rd=%h v=%b d=%h", $time, bus.dmem_addr,
                         bus.dmem_data_i, bus.tx_valid, bus.tx_data, m_rd(bus.dmem_addr), m_q.size() != 0,
                         m_q.size() != 0 ? m_q[0] : 8'h00);
            end
        end
    end

    initial begin
        bus.dmem_addr = ST;
        bus.dmem_op = 2'd0;
        bus.dmem_data_o = 32'd0;
        bus.tx_ready = 1'b0;
        model_reset();
        #12 rst = 1'b0;
        #1;
        chk("reset_status", bus.dmem_data_i, 32'h1);
        chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("reset_tx_data", 32'(bus.tx_data), 32'h0);
        repeat (9) tick();
        drive(CY); expect_rd("cycle_after_10", 32'd10);
        drive(DR); expect_rd("reset_drop", 32'd0);

        drive(32'h100, 2'd3, 32'hA1B2C3D4);
        drive(32'h100); expect_rd("sw_load_0", 32'hA1B2C3D4);
        drive(32'h101); expect_rd("sw_load_1", 32'h00A1B2C3);
        drive(32'h103); expect_rd("sw_load_3", 32'h000000A1);
        drive(32'h102, 2'd1, 32'h5A);
        drive(32'h100); expect_rd("sb_lane2", 32'hA15AC3D4);
        drive(32'h101, 2'd2, 32'hFFFF);
        drive(32'h100); expect_rd("sh_misaligned_nowrite", 32'hA15AC3D4);
        drive(ST); expect_rd("sh_misalign_flag", 32'h5);
        drive(ST, 2'd3, 32'h0);
        drive(ST); expect_rd("status_clear", 32'h1);
        drive(32'h102, 2'd3, 32'h0);
        drive(32'h100); expect_rd("sw_misaligned_nowrite", 32'hA15AC3D4);
        drive(ST); expect_rd("sw_misalign_flag", 32'h5);
        drive(ST, 2'd1, 32'h0);
        drive(ST); expect_rd("status_clear_sb", 32'h1);
        drive(32'h102, 2'd2, 32'hBEEF);
        drive(32'h100); expect_rd("sh_upper_half", 32'hBEEFC3D4);
        drive(32'h102); expect_rd("sh_upper_shifted", 32'h0000BEEF);

        for (int i = 0; i < 10; i++) drive(TX, 2'd1, 32'h41 + i);
        drive(ST); expect_rd("fifo_full_status", 32'h82);
        drive(DR); expect_rd("drop_two", 32'd2);
        for (int i = 0; i < 8; i++) begin
            drive(ST, 2'd0, 32'd0, 1'b1);
            #1;
            chk("drain_valid", 32'(bus.tx_valid), 32'h1);
            chk("drain_byte", 32'(bus.tx_data), 32'h41 + i);
        end
        drive(ST, 2'd0, 32'd0, 1'b1);
        #1 chk("drain_empty", 32'(bus.tx_valid), 32'h0);

        for (int i = 0; i < 8; i++) drive(TX, 2'd1, 32'h60 + i);
        drive(TX, 2'd1, 32'h55, 1'b1);
        drive(ST); expect_rd("full_push_pop_status", 32'h82);
        chk("full_push_pop_head", 32'(bus.tx_data), 32'h61);
        drive(DR); expect_rd("full_push_pop_drop", 32'd2);
        drive(32'h8000_000D, 2'd2, 32'h1234);
        drive(DR); expect_rd("mmio_misaligned_drop_clear", 32'd0);
        drive(ST); expect_rd("mmio_no_misalign", 32'h82);

        drive(CY, 2'd3, 32'hFFFF_FFFE);
        drive(CY); expect_rd("cycle_written", 32'hFFFF_FFFE);
        drive(CY); expect_rd("cycle_max", 32'hFFFF_FFFF);
        drive(CY); expect_rd("cycle_wrap", 32'h0);
        drive(CY, 2'd1, 32'h1FF);
        drive(CY); expect_rd("cycle_sb_zero_ext", 32'hFF);

        drive(ST);
        for (int i = 0; i < 6; i++) drive(ST, 2'd0, 32'd0, 1'b1);
        #1 chk("pre_reset_head", 32'(bus.tx_data), 32'h66);
        #1 rst = 1'b1;
        model_reset();
        #1 chk("reset_drops_valid", 32'(bus.tx_valid), 32'h0);
        #2 rst = 1'b0;
        #1 chk("post_reset_status", bus.dmem_data_i, 32'h1);
        drive(DR); expect_rd("post_reset_drop", 32'd0);
        drive(ST);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
